control_fsm: RTL

// Multicycle main controller for the RV32I core. It sequences fetch, decode, execute, memory and writeback,
// and drives the datapath mux selects and write strobes (AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite,

---
 rtl/control_fsm_pkg.sv | 60 ++++++
 rtl/control_fsm_outdec.sv | 73 +++++++
 rtl/control_fsm.sv | 95 +++++++++
 3 files changed

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, state codes,
// mux-select and ALUOp values, and the control word passed between decoder and top.
package control_fsm_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LWTYPE = 7'b0000011;
   localparam logic [6:0] OP_STYPE  = 7'b0100011;
   localparam logic [6:0] OP_BTYPE  = 7'b1100011;
   localparam logic [6:0] OP_JTYPE  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;

   typedef struct packed {
      logic       adr_src;
      logic       ir_write;
      logic       pc_update;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [2:0] alu_op;
   } ctrl_t;

   function automatic logic is_supported_op(input logic [6:0] op);
      return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LWTYPE) ||
             (op == OP_STYPE) || (op == OP_BTYPE) || (op == OP_JTYPE);
   endfunction

endpackage

// File: rtl/control_fsm_outdec.sv
// Combinational control-word decoder: (state, mem_ready) -> datapath selects and strobes.
module control_fsm_outdec
   import control_fsm_pkg::*;
(
   input  state_t i_state,
   input  logic   i_mem_ready,
   output ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.alu_src_a  = SRCA_PC;
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.alu_op     = ALUOP_ADD;
            o_ctrl.result_src = RES_ALURESULT;
            o_ctrl.ir_write   = i_mem_ready;
            o_ctrl.pc_update  = i_mem_ready;
         end
         S_DECODE: begin
            o_ctrl.alu_src_a = SRCA_OLDPC;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            o_ctrl.alu_src_a = SRCA_RS1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: o_ctrl.adr_src = 1'b1;
         S_MEMWB: begin
            o_ctrl.result_src = RES_MEMDATA;
            o_ctrl.reg_write  = 1'b1;
         end
         // MemWrite stays asserted through the whole wait for mem_ready.
         S_MEMWRITE: begin
            o_ctrl.adr_src   = 1'b1;
            o_ctrl.mem_write = 1'b1;
         end
         S_EXECUTER: begin
            o_ctrl.alu_src_a = SRCA_RS1;
            o_ctrl.alu_src_b = SRCB_RS2;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            o_ctrl.alu_src_a = SRCA_RS1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.reg_write  = 1'b1;
         end
         S_JAL: begin
            o_ctrl.alu_src_a  = SRCA_OLDPC;
            o_ctrl.alu_src_b  = SRCB_FOUR;
            o_ctrl.alu_op     = ALUOP_ADD;
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.pc_update  = 1'b1;
         end
         S_BEQ: begin
            o_ctrl.alu_src_a  = SRCA_RS1;
            o_ctrl.alu_src_b  = SRCB_RS2;
            o_ctrl.alu_op     = ALUOP_SUB;
            o_ctrl.result_src = RES_ALUOUT;
            o_ctrl.branch     = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I main controller: state register, next-state logic and
// reset-gated control outputs; the per-state control word comes from control_fsm_outdec.
module control_fsm
   import control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCUpdate,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       Branch,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ALUOp,
   output logic [3:0] state,
   output logic       illegal_op
);

   state_t r_state;
   state_t w_next;
   ctrl_t  w_dec;
   ctrl_t  w_ctrl;
   logic   w_illegal;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LWTYPE, OP_STYPE: w_next = S_MEMADR;
               OP_RTYPE:            w_next = S_EXECUTER;
               OP_ITYPE:            w_next = S_EXECUTEI;
               OP_JTYPE:            w_next = S_JAL;
               OP_BTYPE:            w_next = S_BEQ;
               default:             w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (op == OP_LWTYPE) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_JAL:      w_next = S_ALUWB;
         S_BEQ:      w_next = S_FETCH;
         default:    w_next = S_FETCH;
      endcase
   end

   control_fsm_outdec u_outdec (
      .i_state     (r_state),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_dec)
   );

   // Reset forces every strobe low immediately; mux selects are left as decoded.
   always_comb begin
      w_ctrl    = w_dec;
      w_illegal = (r_state == S_DECODE) && !is_supported_op(op);
      if (reset) begin
         w_ctrl.ir_write  = 1'b0;
         w_ctrl.pc_update = 1'b0;
         w_ctrl.reg_write = 1'b0;
         w_ctrl.mem_write = 1'b0;
         w_ctrl.branch    = 1'b0;
         w_illegal        = 1'b0;
      end
   end

   assign AdrSrc     = w_ctrl.adr_src;
   assign IRWrite    = w_ctrl.ir_write;
   assign PCUpdate   = w_ctrl.pc_update;
   assign RegWrite   = w_ctrl.reg_write;
   assign MemWrite   = w_ctrl.mem_write;
   assign Branch     = w_ctrl.branch;
   assign ALUSrcA    = w_ctrl.alu_src_a;
   assign ALUSrcB    = w_ctrl.alu_src_b;
   assign ResultSrc  = w_ctrl.result_src;
   assign ALUOp      = w_ctrl.alu_op;
   assign state      = r_state;
   assign illegal_op = w_illegal;

endmodule
